// File: rtl/cross_window_gen.sv
// cross_window_gen
// Streams raster-order pixels and emits one 5-point cross window (centre, up,
// down, left, right) per frame pixel, with edge neighbours replaced by the
// centre value. The window for centre index k leaves one clock after the
// pixel at index k+IMG_W is accepted; the bottom row is produced by a FLUSH
// phase that needs no input.
//
// Handshake: a pixel is accepted on a rising edge where pix_valid & in_ready.
// in_ready is low only during FLUSH. win_valid is a one-cycle pulse per
// window; win_a..win_e hold their values while win_valid is low.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   pix_in, pix_valid     input pixel and its valid
//   sof                   start of frame, qualifies the pixel it travels with
//   in_ready              block accepts input
//   win_a..win_e          centre, up, down, left, right
//   win_valid, win_last   window valid pulse, final window of a frame
module cross_window_gen #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic             in_ready,
    output logic [PIX_W-1:0] win_a,
    output logic [PIX_W-1:0] win_b,
    output logic [PIX_W-1:0] win_c,
    output logic [PIX_W-1:0] win_d,
    output logic [PIX_W-1:0] win_e,
    output logic             win_valid,
    output logic             win_last
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // x_q/y_q address the incoming pixel (during FLUSH: the centre column).
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    logic adv;      // shift the window pipeline and write the line buffers
    logic emit;     // a window is produced this cycle
    logic last;     // that window is the final one of the frame
    logic restart;  // sof pixel accepted: becomes index 0 of a new frame

    logic [XW-1:0] ix;   // column of the incoming pixel
    logic [XW-1:0] wa1;  // line buffer 1 write column

    // lb1 is written one column behind the read column, so reading at ix
    // returns the pixel IMG_W-1 accepts old: the right neighbour of the
    // centre. lb2 delays the centre stream by one more line to give "up".
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];
    logic [PIX_W-1:0] lb1_rd, lb2_rd;

    logic [PIX_W-1:0] cen_q;   // centre pixel
    logic [PIX_W-1:0] left_q;  // pixel to the left of centre

    logic [PIX_W-1:0] nxt_b, nxt_c, nxt_d, nxt_e;

    assign in_ready = (state_q != FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        adv     = 1'b0;
        emit    = 1'b0;
        last    = 1'b0;
        restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (pix_valid && sof) begin
                    restart = 1'b1;
                end
            end
            FILL, STREAM: begin
                if (pix_valid) begin
                    if (sof) begin
                        restart = 1'b1;
                    end else begin
                        adv = 1'b1;
                        if (x_q == X_MAX) begin
                            x_d = '0;
                            if (y_q != Y_MAX) begin
                                y_d = y_q + YW'(1);
                            end
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                        if (state_q == FILL) begin
                            // Index IMG_W completes window 0.
                            if (x_q == '0 && y_q == YW'(1)) begin
                                emit    = 1'b1;
                                state_d = STREAM;
                            end
                        end else begin
                            emit = 1'b1;
                            if (x_q == X_MAX && y_q == Y_MAX) begin
                                state_d = FLUSH;
                            end
                        end
                    end
                end
            end
            FLUSH: begin
                adv  = 1'b1;
                emit = 1'b1;
                if (x_q == X_MAX) begin
                    last    = 1'b1;
                    state_d = IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            adv     = 1'b1;
            state_d = FILL;
            x_d     = XW'(1);
            y_d     = '0;
        end
    end

    assign ix     = restart ? '0 : x_q;
    assign wa1    = (ix == '0) ? X_MAX : ix - XW'(1);
    assign lb1_rd = lb1[ix];
    assign lb2_rd = lb2[ix];

    // Edge replacement. The centre row is y_q-1 while streaming and the last
    // row during FLUSH, so "up" is missing when y_q==1 outside FLUSH and
    // "down" is missing throughout FLUSH.
    always_comb begin
        nxt_b = ((state_q != FLUSH) && (y_q == YW'(1))) ? cen_q : lb2_rd;
        nxt_c = (state_q == FLUSH) ? cen_q : pix_in;
        nxt_d = (ix == '0) ? cen_q : left_q;
        nxt_e = (ix == X_MAX) ? cen_q : lb1_rd;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            lb1[wa1] <= pix_in;
            lb2[ix]  <= cen_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            cen_q     <= '0;
            left_q    <= '0;
            win_a     <= '0;
            win_b     <= '0;
            win_c     <= '0;
            win_d     <= '0;
            win_e     <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            win_valid <= emit;
            win_last  <= last;
            if (emit) begin
                win_a <= cen_q;
                win_b <= nxt_b;
                win_c <= nxt_c;
                win_d <= nxt_d;
                win_e <= nxt_e;
            end
            if (adv) begin
                cen_q  <= lb1_rd;
                left_q <= cen_q;
            end
        end
    end

endmodule
